// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-resolution definitions: funct3 encodings, operand width default,
// the latency legality check and the funct3 -> taken decoder.
package branch_resolve_unit_pkg;

    localparam int DEFAULT_REG_WIDTH = 32;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef struct packed {
        logic eq;
        logic lt;
        logic taken;
        logic illegal;
    } br_result_t;

    function automatic logic latency_legal(input int lat);
        return (lat == 1) || (lat == 2);
    endfunction

    // lt must already reflect the signedness implied by funct3[1].
    function automatic br_result_t br_decode(input logic [2:0] f3, input logic eq, input logic lt);
        br_result_t r;
        r.eq      = eq;
        r.lt      = lt;
        r.taken   = 1'b0;
        r.illegal = 1'b0;
        case (f3)
            BR_BEQ:  r.taken = eq;
            BR_BNE:  r.taken = ~eq;
            BR_BLT:  r.taken = lt;
            BR_BGE:  r.taken = ~lt;
            BR_BLTU: r.taken = lt;
            BR_BGEU: r.taken = ~lt;
            default: begin
                r.lt      = 1'b0;
                r.illegal = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational equality / less-than on one operand slice, signed or unsigned.
module br_half_cmp #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_signed,
    output logic         eq,
    output logic         lt
);

    assign eq = (a == b);
    assign lt = is_signed ? ($signed(a) < $signed(b)) : (a < b);

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compare, decode funct3, registered result with
// stall/flush control and saturating branch / mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int REG_WIDTH = DEFAULT_REG_WIDTH,
    parameter int LATENCY   = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 clr_cnt,
    input  logic [2:0]           funct3,
    input  logic [REG_WIDTH-1:0] data_rs1,
    input  logic [REG_WIDTH-1:0] data_rs2,
    input  logic                 pred_taken,
    output logic                 out_valid,
    output logic                 br_eq,
    output logic                 br_lt,
    output logic                 taken,
    output logic                 mispredict,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] cnt_branches,
    output logic [CNT_WIDTH-1:0] cnt_mispred
);

    localparam int HALF = REG_WIDTH / 2;

    if (!latency_legal(LATENCY) || (REG_WIDTH < 4) || (REG_WIDTH % 2 != 0)) begin : g_param_check
        $error("branch_resolve_unit: illegal LATENCY or REG_WIDTH");
    end

    // Compare results presented to the output stage this cycle.
    logic       nxt_valid;
    logic       nxt_eq;
    logic       nxt_lt;
    logic       nxt_pred;
    logic [2:0] nxt_funct3;

    if (LATENCY == 1) begin : g_lat1
        logic full_eq;
        logic full_lt;

        br_half_cmp #(.W(REG_WIDTH)) u_cmp (
            .a         (data_rs1),
            .b         (data_rs2),
            .is_signed (~funct3[1]),
            .eq        (full_eq),
            .lt        (full_lt)
        );

        assign nxt_valid  = in_valid;
        assign nxt_eq     = full_eq;
        assign nxt_lt     = full_lt;
        assign nxt_pred   = pred_taken;
        assign nxt_funct3 = funct3;
    end else begin : g_lat2
        logic       lo_eq, lo_lt, hi_eq, hi_lt;
        logic       s1_valid;
        logic       s1_eq_lo, s1_lt_lo, s1_eq_hi, s1_lt_hi;
        logic       s1_pred;
        logic [2:0] s1_funct3;

        // The low half is always an unsigned magnitude; only the high half carries the sign.
        br_half_cmp #(.W(HALF)) u_cmp_lo (
            .a         (data_rs1[HALF-1:0]),
            .b         (data_rs2[HALF-1:0]),
            .is_signed (1'b0),
            .eq        (lo_eq),
            .lt        (lo_lt)
        );

        br_half_cmp #(.W(REG_WIDTH - HALF)) u_cmp_hi (
            .a         (data_rs1[REG_WIDTH-1:HALF]),
            .b         (data_rs2[REG_WIDTH-1:HALF]),
            .is_signed (~funct3[1]),
            .eq        (hi_eq),
            .lt        (hi_lt)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid  <= 1'b0;
                s1_eq_lo  <= 1'b0;
                s1_lt_lo  <= 1'b0;
                s1_eq_hi  <= 1'b0;
                s1_lt_hi  <= 1'b0;
                s1_pred   <= 1'b0;
                s1_funct3 <= 3'b000;
            end else if (flush) begin
                s1_valid <= 1'b0;
            end else if (!stall) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_eq_lo  <= lo_eq;
                    s1_lt_lo  <= lo_lt;
                    s1_eq_hi  <= hi_eq;
                    s1_lt_hi  <= hi_lt;
                    s1_pred   <= pred_taken;
                    s1_funct3 <= funct3;
                end
            end
        end

        assign nxt_valid  = s1_valid;
        assign nxt_eq     = s1_eq_hi & s1_eq_lo;
        assign nxt_lt     = s1_lt_hi | (s1_eq_hi & s1_lt_lo);
        assign nxt_pred   = s1_pred;
        assign nxt_funct3 = s1_funct3;
    end

    br_result_t res;
    logic       res_event;
    logic       out_valid_q, br_eq_q, br_lt_q, taken_q, illegal_q, pred_q;

    assign res       = br_decode(nxt_funct3, nxt_eq, nxt_lt);
    assign res_event = nxt_valid & ~stall & ~flush;

    // Result fields only load on a real result so they hold across bubbles and flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            br_eq_q     <= 1'b0;
            br_lt_q     <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            pred_q      <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (!stall) begin
            out_valid_q <= nxt_valid;
            if (nxt_valid) begin
                br_eq_q   <= res.eq;
                br_lt_q   <= res.lt;
                taken_q   <= res.taken;
                illegal_q <= res.illegal;
                pred_q    <= nxt_pred;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_branches <= '0;
            cnt_mispred  <= '0;
        end else if (res_event) begin
            if (cnt_branches != '1) cnt_branches <= cnt_branches + CNT_WIDTH'(1);
            if ((res.taken ^ nxt_pred) && (cnt_mispred != '1)) cnt_mispred <= cnt_mispred + CNT_WIDTH'(1);
        end
    end

    assign out_valid  = out_valid_q;
    assign br_eq      = br_eq_q;
    assign br_lt      = br_lt_q;
    assign taken      = taken_q;
    assign mispredict = out_valid_q & (taken_q ^ pred_q);
    assign illegal    = out_valid_q & illegal_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Pipelined, parametrised branch resolution unit for the EX stage of the RISC-V 5-stage core.
- Decodes the branch funct3 and compares rs1/rs2 with signed or unsigned semantics.
- Produces a registered taken decision and a mispredict flag against the fetch-stage prediction.
- Supports stall hold, flush kill and saturating performance counters. Latency is 1 or 2 cycles, selectable for wide datapaths.

Parameters:
- REG_WIDTH, `REG_WIDTH (32): operand width; must be even and >= 4.
- LATENCY, 1: compare latency in cycles; legal values 1 and 2. LATENCY=2 splits the compare into low and high halves.
- CNT_WIDTH, 32: width of each performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  branch instruction present this cycle
- stall  in  1  pipeline stall; hold all state
- flush  in  1  kill all in-flight branches
- clr_cnt  in  1  synchronous clear of the performance counters
- funct3  in  3  branch type
- data_rs1  in  REG_WIDTH  operand rs1 (forwarded)
- data_rs2  in  REG_WIDTH  operand rs2 (forwarded)
- pred_taken  in  1  fetch-stage prediction for this branch
- out_valid  out  1  result valid
- br_eq  out  1  rs1 == rs2
- br_lt  out  1  rs1 < rs2 (signed or unsigned per funct3)
- taken  out  1  branch resolved taken
- mispredict  out  1  taken != pred_taken, qualified by out_valid
- illegal  out  1  funct3 of 010 or 011 with out_valid
- cnt_branches  out  CNT_WIDTH  resolved branches
- cnt_mispred  out  CNT_WIDTH  mispredicted branches

Behaviour:
- Reset: every output and every internal stage register is 0 on the cycle after rst=1. rst has priority over all other inputs.
- funct3 decode:
  - 000 BEQ: taken = eq
  - 001 BNE: taken = !eq
  - 100 BLT: taken = lt_signed
  - 101 BGE: taken = !lt_signed
  - 110 BLTU: taken = lt_unsigned
  - 111 BGEU: taken = !lt_unsigned
  - 010/011: taken=0, br_lt=0, illegal=1.
  - br_un is derived internally as funct3[1].
- LATENCY=1: inputs are captured at the clk edge where in_valid=1 and stall=0. Outputs are valid in the following cycle.
- LATENCY=2:
  - Stage 1 registers eq_lo, lt_lo (always unsigned on the low half) and eq_hi, lt_hi (signed or unsigned on the high half), plus funct3 and pred_taken.
  - Stage 2 computes eq = eq_hi & eq_lo and lt = lt_hi | (eq_hi & lt_lo).
  - Result is visible two cycles after capture.
  - Results must be bit-identical to LATENCY=1.
- Pipeline, one valid bit per stage:
  - stall=1: no stage advances and no new capture. Outputs hold their values and out_valid holds.
  - flush=1: every valid bit clears at the next edge, and any in_valid in the same cycle is discarded. flush overrides stall.
  - With stall=0, an in_valid=0 cycle inserts a bubble.
- Counters:
  - Increment exactly once per result, on the edge where the result first becomes valid at the output stage. A stalled result is not recounted.
  - cnt_branches counts all such results, including illegal ones. cnt_mispred counts results with mispredict=1; illegal results count as mispredicted when pred_taken=1.
  - Both counters saturate at all-ones.
  - clr_cnt=1 zeroes both counters at the next edge. If clr_cnt coincides with an increment event, clr_cnt wins.
  - Counters ignore flush.
- Signed compare uses $signed on the full operand. Unsigned compare zero-extends. No arithmetic overflow is possible.
- When out_valid=0, the mispredict and illegal outputs are forced to 0. br_eq, br_lt and taken still hold their last values.

Decomposition:
- Shared package / risc_v_defines.vh:
  - funct3 branch constants BR_BEQ..BR_BGEU
  - LATENCY legality check macro
  - REG_WIDTH
- One sub-module, br_half_cmp: a combinational eq/lt on a half-width slice, with a signed-mode input. It is instantiated twice for LATENCY=2 and once at full width for LATENCY=1.

Test Plan:
- BLT signed, REG_WIDTH=32: rs1=0xFFFFFFFF, rs2=0x00000001, funct3=100, pred_taken=0 → one cycle later out_valid=1, br_lt=1, taken=1, mispredict=1, cnt_mispred=1. Same operands with funct3=110 → taken=0.
- LATENCY=2, REG_WIDTH=64, BGEU: rs1=0x0000000100000000, rs2=0x00000000FFFFFFFF → result after 2 cycles with taken=1. Equal operands with BNE → taken=0. Run 10k random operand/funct3 vectors against a golden model; both latencies must match.
- Stall: capture a BEQ on equal operands, then hold stall=1 for 3 cycles → out_valid stays 1, taken stays 1, cnt_branches increments only once.
- Flush: issue a branch at cycle N with flush=1 at cycle N+1 (LATENCY=2) → no out_valid ever appears and counters are unchanged. A branch issued while flush=1 is dropped.
- Illegal funct3=010 with pred_taken=1 → illegal=1, taken=0, mispredict=1. rst=1 for one cycle mid-stream → all outputs 0 on the next cycle.
- Counter limits, CNT_WIDTH=4: 20 mispredicted branches → both counters stay at 0xF. clr_cnt asserted together with a completing branch → both counters read 0.
